// File: rtl/demux_1to8_reg.sv
// Registered 1-to-8 demultiplexer: a 1:2 split on s[2] feeds two 1:4 stages on s[1:0].
// The decoded word is captured when en is set, and synchronous rst clears every output.
module demux_1to8_reg #(
    parameter int unsigned DATA_W = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] i,
    input  logic [2:0]        s,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] c,
    output logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] e,
    output logic [DATA_W-1:0] f,
    output logic [DATA_W-1:0] g,
    output logic [DATA_W-1:0] h
);

    logic [DATA_W-1:0]       low_half;
    logic [DATA_W-1:0]       high_half;
    logic [3:0][DATA_W-1:0]  low_dec;
    logic [3:0][DATA_W-1:0]  high_dec;
    logic [7:0][DATA_W-1:0]  out_d;
    logic [7:0][DATA_W-1:0]  out_q;

    always_comb begin
        low_half  = s[2] ? '0 : i;
        high_half = s[2] ? i  : '0;

        low_dec            = '0;
        high_dec           = '0;
        low_dec[s[1:0]]    = low_half;
        high_dec[s[1:0]]   = high_half;

        // Index 0..3 is a..d, index 4..7 is e..h.
        out_d = out_q;
        if (en) begin
            out_d = {high_dec, low_dec};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign a = out_q[0];
    assign b = out_q[1];
    assign c = out_q[2];
    assign d = out_q[3];
    assign e = out_q[4];
    assign f = out_q[5];
    assign g = out_q[6];
    assign h = out_q[7];

endmodule

// File: tb/tb_demux_1to8_reg.sv
// Bench for demux_1to8_reg: 1-bit and 8-bit instances share rst/en/s and are compared
// each cycle against a register-file model of the eight outputs.
module tb_demux_1to8_reg;

    logic       clk;
    logic       rst;
    logic       en;
    logic       i1;
    logic [7:0] i8;
    logic [2:0] s;

    logic       a1, b1, c1, d1, e1, f1, g1, h1;
    logic [7:0] a8, b8, c8, d8, e8, f8, g8, h8;

    logic [7:0] m1 [8];
    logic [7:0] m8 [8];

    int checks;
    int passed;

    demux_1to8_reg #(.DATA_W(1)) u_dut1 (
        .clk (clk), .rst (rst), .en (en), .i (i1), .s (s),
        .a (a1), .b (b1), .c (c1), .d (d1), .e (e1), .f (f1), .g (g1), .h (h1)
    );

    demux_1to8_reg #(.DATA_W(8)) u_dut8 (
        .clk (clk), .rst (rst), .en (en), .i (i8), .s (s),
        .a (a8), .b (b8), .c (c8), .d (d8), .e (e8), .f (f8), .g (g8), .h (h8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    // Apply one cycle of stimulus, advance the model past the edge, then compare.
    task automatic step(input string tag, input logic r, input logic ev, input logic iv1,
                        input logic [7:0] iv8, input logic [2:0] sv);
        logic [7:0] o1 [8];
        logic [7:0] o8 [8];
        rst = r;
        en  = ev;
        i1  = iv1;
        i8  = iv8;
        s   = sv;
        @(posedge clk);
        #1;
        for (int k = 0; k < 8; k++) begin
            if (r) begin
                m1[k] = 8'h00;
                m8[k] = 8'h00;
            end else if (ev) begin
                m1[k] = (k == int'(sv)) ? {7'b0, iv1} : 8'h00;
                m8[k] = (k == int'(sv)) ? iv8 : 8'h00;
            end
        end
        o1 = '{{7'b0, a1}, {7'b0, b1}, {7'b0, c1}, {7'b0, d1},
               {7'b0, e1}, {7'b0, f1}, {7'b0, g1}, {7'b0, h1}};
        o8 = '{a8, b8, c8, d8, e8, f8, g8, h8};
        for (int k = 0; k < 8; k++) begin
            check($sformatf("%s.w1.%c", tag, 8'(97 + k)), o1[k], m1[k]);
            check($sformatf("%s.w8.%c", tag, 8'(97 + k)), o8[k], m8[k]);
        end
    endtask

    initial begin
        logic [3:0] v;
        checks = 0;
        passed = 0;
        rst = 1'b1;
        en  = 1'b1;
        i1  = 1'b1;
        i8  = 8'hFF;
        s   = 3'd5;
        for (int k = 0; k < 8; k++) begin
            m1[k] = 8'h00;
            m8[k] = 8'h00;
        end

        step("reset0", 1'b1, 1'b1, 1'b1, 8'hFF, 3'd5);
        step("reset1", 1'b1, 1'b1, 1'b1, 8'hFF, 3'd5);

        for (int k = 0; k < 8; k++) begin
            step($sformatf("sweep%0d", k), 1'b0, 1'b1, 1'b1, 8'(8'h11 * (k + 1)), 3'(k));
        end

        step("zero", 1'b0, 1'b1, 1'b0, 8'h00, 3'd6);

        step("hold_cap", 1'b0, 1'b1, 1'b1, 8'h3C, 3'd3);
        for (int k = 0; k < 3; k++) begin
            step($sformatf("hold%0d", k), 1'b0, 1'b0, 1'b0, 8'h00, 3'd7);
        end

        for (int k = 0; k < 10; k++) begin
            v = 4'($urandom_range(0, 15));
            step($sformatf("rand%0d", k), 1'b0, 1'b1, v[3], 8'($urandom), v[2:0]);
        end

        step("width", 1'b0, 1'b1, 1'b1, 8'hA5, 3'd2);
        step("midrst", 1'b1, 1'b1, 1'b1, 8'h5A, 3'd4);
        step("post_rst", 1'b0, 1'b1, 1'b1, 8'hC3, 3'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
